// File: rtl/multicycle_core_if.sv
// Host-side bus of multicycle_core: run control, memory preload port and status.
interface multicycle_core_if #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned IMEM_DEPTH = 256
);
  localparam int unsigned PcW = $clog2(IMEM_DEPTH);
  localparam int unsigned WdW = (XLEN > 32) ? XLEN : 32;

  logic           start;
  logic           load_we;
  logic           load_mem;
  logic [31:0]    load_addr;
  logic [WdW-1:0] load_wdata;
  logic           signal;
  logic           error;
  logic [PcW-1:0] pc;
  logic [31:0]    instret;

  modport master (
    output start, load_we, load_mem, load_addr, load_wdata,
    input  signal, error, pc, instret
  );

  modport slave (
    input  start, load_we, load_mem, load_addr, load_wdata,
    output signal, error, pc, instret
  );
endinterface

// File: rtl/multicycle_core.sv
// Multi-cycle core with private register file, imem and dmem, driven over a host bus.
// Define CORE_TRAP_EN to halt with error/EPC/cause on undefined opcodes instead of a NOP.
module multicycle_core #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned NREG       = 32,
  parameter int unsigned IMEM_DEPTH = 256,
  parameter int unsigned DMEM_DEPTH = 256
) (
  input logic             clk,
  input logic             reset,
  multicycle_core_if.slave bus
);
  localparam int unsigned PcW = $clog2(IMEM_DEPTH);
  localparam int unsigned DaW = $clog2(DMEM_DEPTH);
  localparam int unsigned RW  = $clog2(NREG);

  localparam logic [5:0] OpAdd  = 6'h00;
  localparam logic [5:0] OpSub  = 6'h01;
  localparam logic [5:0] OpAnd  = 6'h02;
  localparam logic [5:0] OpOr   = 6'h03;
  localparam logic [5:0] OpSlt  = 6'h04;
  localparam logic [5:0] OpBeq  = 6'h05;
  localparam logic [5:0] OpBne  = 6'h06;
  localparam logic [5:0] OpAddi = 6'h08;
  localparam logic [5:0] OpLw   = 6'h23;
  localparam logic [5:0] OpSw   = 6'h2B;
  localparam logic [5:0] OpHalt = 6'h3F;

  typedef enum logic [2:0] {
    StIdle, StFetch, StDecode, StExec, StMem, StWb, StHalted
  } state_e;

  state_e          state_q, state_d;
  logic [PcW-1:0]  pc_q, pc_d;
  logic [31:0]     instret_q, instret_d;
  logic            error_q, error_d;
  logic [31:0]     ir_q, ir_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN-1:0] alu_q, alu_d;

  logic [XLEN-1:0] rf_q   [NREG];
  logic [31:0]     imem_q [IMEM_DEPTH];
  logic [XLEN-1:0] dmem_q [DMEM_DEPTH];

  logic            rf_we;
  logic [RW-1:0]   rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic            imem_we;
  logic            dmem_we;
  logic [DaW-1:0]  dmem_waddr;
  logic [XLEN-1:0] dmem_wdata;
  logic            taken;

  logic [5:0]      op;
  logic [RW-1:0]   rd, rs, rt;
  logic [XLEN-1:0] imm_x;
  logic [PcW-1:0]  pc_inc;

  assign op     = ir_q[31:26];
  assign rd     = ir_q[21 +: RW];
  assign rs     = ir_q[16 +: RW];
  assign rt     = ir_q[11 +: RW];
  assign imm_x  = XLEN'($signed(ir_q[15:0]));
  assign pc_inc = pc_q + PcW'(1);

`ifdef CORE_TRAP_EN
  logic [PcW-1:0] epc_q, epc_d;
  logic [5:0]     cause_q, cause_d;
`endif

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instret_d  = instret_q;
    error_d    = error_q;
    ir_d       = ir_q;
    a_d        = a_q;
    b_d        = b_q;
    alu_d      = alu_q;
    rf_we      = 1'b0;
    rf_waddr   = rd;
    rf_wdata   = alu_q;
    imem_we    = 1'b0;
    dmem_we    = 1'b0;
    dmem_waddr = alu_q[DaW-1:0];
    dmem_wdata = b_q;
    taken      = 1'b0;
`ifdef CORE_TRAP_EN
    epc_d      = epc_q;
    cause_d    = cause_q;
`endif

    if ((state_q == StIdle || state_q == StHalted) && bus.load_we) begin
      if (bus.load_mem) begin
        dmem_we    = 1'b1;
        dmem_waddr = bus.load_addr[DaW-1:0];
        dmem_wdata = bus.load_wdata[XLEN-1:0];
      end else begin
        imem_we = 1'b1;
      end
    end

    unique case (state_q)
      StIdle, StHalted: begin
        if (bus.start) begin
          state_d   = StFetch;
          pc_d      = '0;
          instret_d = '0;
          error_d   = 1'b0;
        end
      end
      StFetch: begin
        ir_d    = imem_q[pc_q];
        state_d = StDecode;
      end
      StDecode: begin
        a_d = (rs == '0) ? '0 : rf_q[rs];
        // R-type reads rt as the second operand; SW and branches read rd.
        if (op inside {OpAdd, OpSub, OpAnd, OpOr, OpSlt}) begin
          b_d = (rt == '0) ? '0 : rf_q[rt];
        end else begin
          b_d = (rd == '0) ? '0 : rf_q[rd];
        end
        state_d = StExec;
      end
      StExec: begin
        case (op)
          OpAdd:  begin alu_d = a_q + b_q;  state_d = StWb; end
          OpSub:  begin alu_d = a_q - b_q;  state_d = StWb; end
          OpAnd:  begin alu_d = a_q & b_q;  state_d = StWb; end
          OpOr:   begin alu_d = a_q | b_q;  state_d = StWb; end
          OpSlt:  begin
            alu_d   = XLEN'(($signed(a_q) < $signed(b_q)) ? 1 : 0);
            state_d = StWb;
          end
          OpAddi: begin alu_d = a_q + imm_x; state_d = StWb; end
          OpLw, OpSw: begin
            alu_d   = a_q + imm_x;
            state_d = StMem;
          end
          OpBeq, OpBne: begin
            taken     = (op == OpBeq) == (a_q == b_q);
            pc_d      = taken ? (pc_inc + PcW'(imm_x)) : pc_inc;
            instret_d = instret_q + 32'd1;
            state_d   = StFetch;
          end
          OpHalt: begin
            pc_d      = pc_inc;
            instret_d = instret_q + 32'd1;
            state_d   = StHalted;
          end
          default: begin
`ifdef CORE_TRAP_EN
            error_d = 1'b1;
            epc_d   = pc_q;
            cause_d = op;
            state_d = StHalted;
`else
            pc_d      = pc_inc;
            instret_d = instret_q + 32'd1;
            state_d   = StFetch;
`endif
          end
        endcase
      end
      StMem: begin
        if (op == OpLw) begin
          alu_d   = dmem_q[alu_q[DaW-1:0]];
          state_d = StWb;
        end else begin
          dmem_we   = 1'b1;
          pc_d      = pc_inc;
          instret_d = instret_q + 32'd1;
          state_d   = StFetch;
        end
      end
      StWb: begin
        rf_we     = (rd != '0);
        pc_d      = pc_inc;
        instret_d = instret_q + 32'd1;
        state_d   = StFetch;
      end
      default: state_d = StIdle;
    endcase

    // Reset aborts the instruction in flight, including any pending write.
    if (reset) begin
      rf_we   = 1'b0;
      imem_we = 1'b0;
      dmem_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      pc_q      <= '0;
      instret_q <= '0;
      error_q   <= 1'b0;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instret_q <= instret_d;
      error_q   <= error_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      alu_q     <= alu_d;
    end
  end

`ifdef CORE_TRAP_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      epc_q   <= '0;
      cause_q <= '0;
    end else begin
      epc_q   <= epc_d;
      cause_q <= cause_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (rf_we) begin
      rf_q[rf_waddr] <= rf_wdata;
    end
  end

  // Memories have no reset: contents survive reset and start.
  always_ff @(posedge clk) begin
    if (imem_we) imem_q[bus.load_addr[PcW-1:0]] <= bus.load_wdata[31:0];
  end

  always_ff @(posedge clk) begin
    if (dmem_we) dmem_q[dmem_waddr] <= dmem_wdata;
  end

  assign bus.signal  = (state_q == StHalted);
  assign bus.error   = error_q;
  assign bus.pc      = pc_q;
  assign bus.instret = instret_q;

  logic unused_bits;
`ifdef CORE_TRAP_EN
  assign unused_bits = ^{bus.load_addr, bus.load_wdata, alu_q, ir_q, epc_q, cause_q};
`else
  assign unused_bits = ^{bus.load_addr, bus.load_wdata, alu_q, ir_q};
`endif
endmodule

// File: tb/tb_multicycle_core.sv
// Directed bench for multicycle_core: default-width core plus a 16-bit XLEN instance.
module tb_multicycle_core;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  multicycle_core_if #(.XLEN(32), .IMEM_DEPTH(256)) bus ();
  multicycle_core_if #(.XLEN(16), .IMEM_DEPTH(256)) bus16 ();

  multicycle_core #(.XLEN(32), .NREG(32), .IMEM_DEPTH(256), .DMEM_DEPTH(256)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  multicycle_core #(.XLEN(16), .NREG(32), .IMEM_DEPTH(256), .DMEM_DEPTH(256)) u_dut16 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus16.slave)
  );

  localparam logic [31:0] Halt = 32'hFC00_0000;

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rd, input int rs,
                                        input int imm);
    return {op, 5'(rd), 5'(rs), 16'(imm)};
  endfunction

  function automatic logic [31:0] enc_r(input logic [5:0] op, input int rd, input int rs,
                                        input int rt);
    return {op, 5'(rd), 5'(rs), 5'(rt), 11'd0};
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input bit sel16, input logic mem, input int unsigned addr,
                           input logic [31:0] data);
    if (sel16) begin
      bus16.load_we = 1'b1; bus16.load_mem = mem; bus16.load_addr = addr; bus16.load_wdata = data;
    end else begin
      bus.load_we = 1'b1; bus.load_mem = mem; bus.load_addr = addr; bus.load_wdata = data;
    end
    tick();
    bus.load_we   = 1'b0;
    bus16.load_we = 1'b0;
  endtask

  // Pulse start (optionally with a simultaneous imem load), count edges until signal.
  task automatic run(input bit sel16, input bit with_load, input int unsigned addr,
                     input logic [31:0] data, input int unsigned budget,
                     output int unsigned cycles);
    if (sel16) begin
      bus16.start = 1'b1;
    end else begin
      bus.start = 1'b1;
      if (with_load) begin
        bus.load_we = 1'b1; bus.load_mem = 1'b0; bus.load_addr = addr; bus.load_wdata = data;
      end
    end
    tick();
    bus.start = 1'b0; bus16.start = 1'b0; bus.load_we = 1'b0; bus16.load_we = 1'b0;
    cycles = 0;
    while (!(sel16 ? bus16.signal : bus.signal) && cycles < budget) begin
      tick();
      cycles++;
    end
  endtask

  int unsigned cyc;

  initial begin
    bus.start = 0; bus.load_we = 0; bus.load_mem = 0; bus.load_addr = 0; bus.load_wdata = 0;
    bus16.start = 0; bus16.load_we = 0; bus16.load_mem = 0; bus16.load_addr = 0;
    bus16.load_wdata = 0;
    tick();
    tick();
    reset = 1'b0;

    check_eq("rst_pc", 64'(bus.pc), 64'd0);
    check_eq("rst_instret", 64'(bus.instret), 64'd0);
    check_eq("rst_signal", 64'(bus.signal), 64'd0);
    check_eq("rst_error", 64'(bus.error), 64'd0);
    check_eq("rst_r5", 64'(u_dut.rf_q[5]), 64'd0);

    // ADDI/ADDI/ADD/HALT; HALT loaded in the same cycle as start.
    load_word(0, 0, 0, enc_i(6'h08, 1, 0, 5));
    load_word(0, 0, 1, enc_i(6'h08, 2, 0, 7));
    load_word(0, 0, 2, enc_r(6'h00, 3, 1, 2));
    run(0, 1, 3, Halt, 100, cyc);
    check_eq("t1_cycles", 64'(cyc), 64'd15);
    check_eq("t1_r3", 64'(u_dut.rf_q[3]), 64'd12);
    check_eq("t1_instret", 64'(bus.instret), 64'd4);
    check_eq("t1_signal", 64'(bus.signal), 64'd1);
    check_eq("t1_error", 64'(bus.error), 64'd0);
    check_eq("t1_pc", 64'(bus.pc), 64'd4);

    // LW then SW through an offset base.
    load_word(0, 1, 3, 32'hA5A5_A5A5);
    load_word(0, 0, 0, enc_i(6'h08, 1, 0, 3));
    load_word(0, 0, 1, enc_i(6'h23, 2, 1, 0));
    load_word(0, 0, 2, enc_i(6'h2B, 2, 1, 1));
    load_word(0, 0, 3, Halt);
    run(0, 0, 0, 0, 100, cyc);
    check_eq("t2_cycles", 64'(cyc), 64'd16);
    check_eq("t2_dmem4", 64'(u_dut.dmem_q[4]), 64'hA5A5_A5A5);
    check_eq("t2_r2", 64'(u_dut.rf_q[2]), 64'hA5A5_A5A5);

    // Count-down loop with a backward BNE.
    load_word(0, 0, 0, enc_i(6'h08, 1, 0, 3));
    load_word(0, 0, 1, enc_i(6'h08, 1, 1, -1));
    load_word(0, 0, 2, enc_i(6'h06, 1, 0, -2));
    load_word(0, 0, 3, Halt);
    run(0, 0, 0, 0, 200, cyc);
    check_eq("t3_cycles", 64'(cyc), 64'd28);
    check_eq("t3_instret", 64'(bus.instret), 64'd8);
    check_eq("t3_r1", 64'(u_dut.rf_q[1]), 64'd0);

    // Undefined opcode 0x3E at PC=2.
    load_word(0, 0, 0, enc_i(6'h08, 5, 0, 1));
    load_word(0, 0, 1, enc_i(6'h08, 5, 5, 1));
    load_word(0, 0, 2, enc_i(6'h3E, 0, 0, 0));
    load_word(0, 0, 3, enc_i(6'h08, 5, 5, 1));
    load_word(0, 0, 4, Halt);
    run(0, 0, 0, 0, 200, cyc);
`ifdef CORE_TRAP_EN
    check_eq("t4_cycles", 64'(cyc), 64'd11);
    check_eq("t4_error", 64'(bus.error), 64'd1);
    check_eq("t4_pc", 64'(bus.pc), 64'd2);
    check_eq("t4_instret", 64'(bus.instret), 64'd2);
    check_eq("t4_r5", 64'(u_dut.rf_q[5]), 64'd2);
`else
    check_eq("t4_cycles", 64'(cyc), 64'd18);
    check_eq("t4_error", 64'(bus.error), 64'd0);
    check_eq("t4_pc", 64'(bus.pc), 64'd5);
    check_eq("t4_instret", 64'(bus.instret), 64'd5);
    check_eq("t4_r5", 64'(u_dut.rf_q[5]), 64'd3);
`endif
    check_eq("t4_signal", 64'(bus.signal), 64'd1);

    // Reset while the SW sits in MEM: the store must not land.
    load_word(0, 1, 4, 32'h0000_1111);
    load_word(0, 0, 0, enc_i(6'h08, 1, 0, 4));
    load_word(0, 0, 1, enc_i(6'h2B, 1, 1, 0));
    load_word(0, 0, 2, Halt);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("t5_dmem4_kept", 64'(u_dut.dmem_q[4]), 64'h1111);
    check_eq("t5_pc", 64'(bus.pc), 64'd0);
    check_eq("t5_instret", 64'(bus.instret), 64'd0);
    check_eq("t5_signal", 64'(bus.signal), 64'd0);
    check_eq("t5_r1", 64'(u_dut.rf_q[1]), 64'd0);
    tick();
    check_eq("t5_dmem4_idle", 64'(u_dut.dmem_q[4]), 64'h1111);
    run(0, 0, 0, 0, 100, cyc);
    check_eq("t5_rerun_cycles", 64'(cyc), 64'd11);
    check_eq("t5_rerun_dmem4", 64'(u_dut.dmem_q[4]), 64'd4);
    check_eq("t5_rerun_instret", 64'(bus.instret), 64'd3);

    // XLEN=16 wrap and discarded r0 writes.
    load_word(1, 0, 0, enc_i(6'h08, 1, 0, -1));
    load_word(1, 0, 1, enc_i(6'h08, 1, 1, 1));
    load_word(1, 0, 2, enc_i(6'h08, 2, 0, 9));
    load_word(1, 0, 3, enc_i(6'h08, 0, 0, 5));
    load_word(1, 0, 4, enc_r(6'h00, 2, 0, 0));
    load_word(1, 0, 5, Halt);
    run(1, 0, 0, 0, 100, cyc);
    check_eq("t6_cycles", 64'(cyc), 64'd23);
    check_eq("t6_r1", 64'(u_dut16.rf_q[1]), 64'h0000);
    check_eq("t6_r2", 64'(u_dut16.rf_q[2]), 64'h0000);
    check_eq("t6_r0", 64'(u_dut16.rf_q[0]), 64'h0000);
    check_eq("t6_instret", 64'(bus16.instret), 64'd6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/multicycle_core.md
# multicycle_core

Parametrised multi-cycle processor core, successor to the single-width processor top. Owns a register file, instruction memory and data memory. Executes a fixed 32-bit instruction set through a fetch/decode/execute/memory/writeback state machine. A host preloads both memories over a load port, pulses `start`, and waits for `signal`; integer width, register count and memory depths are parameters.

## Interface
- `XLEN`, 32: datapath and register width (16..64).
- `NREG`, 32: general registers; power of two in {8,16,32}; register 0 hardwired to zero.
- `IMEM_DEPTH`, 256: instruction words; power of two.
- `DMEM_DEPTH`, 256: data words of XLEN bits; power of two.

- `clk` in 1: single clock; all state changes on rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: begin execution at PC=0; honoured only in IDLE or HALTED.
- `load_we` in 1: memory preload strobe; honoured only in IDLE or HALTED.
- `load_mem` in 1: 0 selects imem, 1 selects dmem.
- `load_addr` in 32: word address, taken modulo target depth.
- `load_wdata` in 32/XLEN: imem uses low 32 bits; dmem uses XLEN bits zero-extended.
- `signal` out 1: 1 while HALTED.
- `error` out 1: 1 when halted by trap.
- `pc` out clog2(IMEM_DEPTH): current program counter.
- `instret` out 32: retired-instruction count, wraps at 2^32.

## Operation
- Instruction fields: op[31:26], rd[25:21], rs[20:16], rt[15:11], imm[15:0] sign-extended to XLEN. Register fields use the low log2(NREG) bits.
- Opcodes:
  - 0x00 ADD, 0x01 SUB, 0x02 AND, 0x03 OR: rd = rs op rt.
  - 0x04 SLT: rd = (signed rs < signed rt).
  - 0x08 ADDI: rd = rs + imm.
  - 0x23 LW: rd = dmem[rs+imm].
  - 0x2B SW: dmem[rs+imm] = rd.
  - 0x05 BEQ, 0x06 BNE: compare rd,rs; if taken, PC = PC+1+imm.
  - 0x3F HALT.
- Arithmetic is modulo 2^XLEN. Data addresses are word addresses modulo DMEM_DEPTH. PC is taken modulo IMEM_DEPTH, so PC wraps from IMEM_DEPTH-1 to 0.
- Writes to register 0 are discarded; reading register 0 returns 0.
- FSM states: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALTED.
  - IDLE/HALTED to FETCH on `start`. `start` clears PC, `instret`, `error` and `signal`. Registers and memories are not cleared.
  - FETCH to DECODE: IR = imem[PC].
  - DECODE to EXEC: operands latched.
  - EXEC:
    - ALU op: to WB.
    - LW/SW: to MEM.
    - Branch: to FETCH.
    - HALT: to HALTED.
  - MEM: LW to WB; SW writes memory, then to FETCH.
  - WB: writes rd, then to FETCH.
- PC advances by 1, or to the branch target, on the exit edge of the final state of each instruction. `instret` increments on that same edge; HALT also counts.
- `start` or `load_we` arriving in FETCH..WB is ignored.
- `load_we` and `start` in the same cycle: the load is performed and execution starts; that load is visible to the first fetch.

## Timing
- Reset values:
  - State IDLE; PC, `instret`, `signal` and `error` all 0.
  - All registers 0.
  - Memories retain their contents.
- Cycles per instruction:
  - ALU, ADDI: 4.
  - LW: 5.
  - SW: 4.
  - BEQ/BNE: 3, taken or not.
  - HALT: 3.
- `signal` rises on the edge that enters HALTED, i.e. 3 cycles after HALT is fetched.
- Reset asserted mid-instruction aborts the instruction: no register or memory write occurs in that cycle, and the core is in IDLE the following cycle.
- Loads write memory on the edge of the `load_we` cycle.

## Configuration
- `CORE_TRAP_EN` defined: an undefined opcode in EXEC sets `error`=1, latches EPC=PC and cause=op, and enters HALTED. Cycle count is 3, and the trapped instruction is not counted in `instret`.
- `CORE_TRAP_EN` undefined: an undefined opcode executes as a 3-cycle NOP, and `instret` increments. `error` stays 0, and no EPC or cause state exists.

## Test plan
- Reset, load imem {ADDI r1,r0,5; ADDI r2,r0,7; ADD r3,r1,r2; HALT}, start.
  - Expect r3=12, `instret`=4, `signal`=1 at cycle 15 after start, `error`=0.
- Preload dmem[3]=0xA5A5A5A5; run {ADDI r1,r0,3; LW r2,0(r1); SW r2,1(r1); HALT}.
  - Expect dmem[4]=0xA5A5A5A5 and 16 cycles to `signal`.
- Count-down loop {ADDI r1,r0,3; ADDI r1,r1,-1; BNE r1,r0,-2; HALT}.
  - Expect 7 retired before HALT, `instret`=8, r1=0.
- Run with XLEN=16: ADDI r1,r0,-1 then ADDI r1,r1,1.
  - Expect r1=0x0000. Also write via rd=0 and expect r0 still 0.
- Illegal opcode 0x3E at PC=2:
  - With `CORE_TRAP_EN`: `error`=1, `pc`=2, HALTED.
  - Without: execution continues to the next HALT, `error`=0.
- Assert reset during MEM of an SW, then start again.
  - Expect no memory write, state IDLE, and a clean re-execution from PC=0.
